seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display that shares a single bcd7seg decoder among all digits. It holds a digit register file loaded through a write port and steps through the digits at a programmable rate. For each digit it drives the shared decoder's b and clear inputs and the active-low anode selects. A blanking gap with all anodes off is inserted between digits to prevent ghosting, and optional leading-zero suppression is supported.

Parameters:
NDIG, 8, number of digits; legal range 2..16.
DIV, 1000, clk cycles each digit is shown; must be >= 1.
GAP, 2, all-off clk cycles between digits; 0 disables the gap.
IW, $clog2(NDIG), digit index width; derived from NDIG, not overridden.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous active-high reset, sampled on the rising edge of clk.
en  in  1  scan enable; 0 forces the display off.
wr_en  in  1  digit write strobe.
wr_idx  in  IW  digit index to write; 0 is the least-significant (rightmost) digit.
wr_val  in  4  hex value to write.
blank_mask  in  NDIG  per-digit force-blank, 1 = blank; sampled live.
lz_en  in  1  leading-zero suppression enable; sampled live.
dec_b  out  4  value to the shared decoder's b input.
dec_clear  out  1  to the shared decoder's clear input; 1 = segments off.
digit_sel  out  NDIG  active-low one-hot anode select.
frame_done  out  1  one-cycle pulse when a full scan frame has completed.

Behaviour:
- Reset, and the cycle after any rst=1 edge, including mid-scan:
  - state=OFF, idx=0, cnt=0, all digit registers=0.
  - dec_b=0, dec_clear=1, digit_sel=all ones, frame_done=0.
- Digit file:
  - On a clk edge with wr_en=1 and wr_idx<NDIG, digit[wr_idx] takes wr_val.
  - Writes with wr_idx>=NDIG are ignored.
  - Writes are accepted in every state, including OFF.
  - rst has priority over wr_en.
- Outputs are combinational from the registered state, idx and digit file. A write to the currently shown digit is visible in the cycle after the write edge.
- State machine, with cnt as the cycle counter:
  - OFF: if en=1, go to SHOW with cnt=0 and idx=0.
  - SHOW: digit_sel[idx]=0, all other bits=1; dec_b=digit[idx]; dec_clear=blk(idx). When cnt==DIV-1, cnt=0 and go to GAP, or, if GAP==0, stay in SHOW with idx advanced. Otherwise cnt increments.
  - GAP: digit_sel=all ones, dec_clear=1, dec_b=digit[idx]. When cnt==GAP-1, cnt=0, idx advances, and go to SHOW. Otherwise cnt increments.
  - Any state with en=0 goes to OFF next edge. idx and cnt clear to 0, and the digit file is kept.
- idx advance: idx+1, wrapping from NDIG-1 to 0.
- frame_done:
  - Registered. High for exactly the one cycle after the edge on which idx wraps from NDIG-1 to 0.
  - Never asserted on an OFF to SHOW entry.
- Blanking, blk(i) = blank_mask[i] OR lz(i):
  - lz(i) = lz_en AND i!=0 AND digit[j]==0 for every j with i <= j <= NDIG-1.
  - Digit 0 is never suppressed by lz.
- Digit period is DIV+GAP cycles; frame period is NDIG*(DIV+GAP) cycles.
- Counter width is sized for max(DIV, GAP)-1; no overflow is possible.

Test Plan (NDIG=4, DIV=3, GAP=1 unless stated):
- Reset, then hold en=0 for 10 cycles -> digit_sel=4'b1111, dec_clear=1, dec_b=0, frame_done=0 throughout.
- Write digits {3:4'h0, 2:4'h7, 1:4'hA, 0:4'h5}, then raise en -> repeating 16-cycle pattern:
  - digit_sel 4'b1110 for 3 cycles with dec_b=5, then 4'b1111 for 1 cycle.
  - 4'b1101 for 3 cycles with dec_b=A, then 4'b1111 for 1 cycle.
  - Likewise for digit 2 (dec_b=7) and digit 3 (dec_b=0).
  - frame_done high exactly once per 16 cycles, on the first digit-0 cycle after wrap.
- Digits {0,0,3,0}, lz_en=1 -> dec_clear=1 while digit 3 or digit 2 is shown; dec_clear=0 for digits 1 and 0. With all digits 0 -> only digit 0 is unblanked.
- blank_mask=4'b0010 -> dec_clear=1 while digit_sel=4'b1101; other digits unaffected.
- Write digit[idx]=F while idx is shown -> dec_b=F from the next cycle. Write with wr_idx>=NDIG (NDIG=3 build, wr_idx=3) -> no register changes.
- Mid-scan events, each checked on the next cycle:
  - Drop en during digit 2 -> outputs off; re-raise en -> restart at digit 0 with no frame_done.
  - Assert rst mid-scan -> reset values, and the digit file is cleared.
  - GAP=0 build -> digit_sel steps with no all-ones cycles; digit period is 3 cycles.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
// Drives one shared bcd7seg decoder plus active-low anode selects, with inter-digit blanking gaps.
module seg_scan_ctrl #(
  parameter int NDIG = 8,
  parameter int DIV  = 1000,
  parameter int GAP  = 2,
  parameter int IW   = $clog2(NDIG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic [3:0]      wr_val,
  input  logic [NDIG-1:0] blank_mask,
  input  logic            lz_en,
  output logic [3:0]      dec_b,
  output logic            dec_clear,
  output logic [NDIG-1:0] digit_sel,
  output logic            frame_done
);

  localparam int MAXC = (DIV > GAP) ? DIV : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    ST_OFF,
    ST_SHOW,
    ST_GAP
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   idx_next;
  logic            idx_wrap;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            frame_q, frame_d;
  logic [3:0]      digit_q [NDIG];
  logic [3:0]      digit_d [NDIG];

  logic [NDIG-1:0] zero_from;
  logic [3:0]      cur_val;
  logic            cur_blk;

  // Index decode by comparison, so out-of-range write indices fall through untouched.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    for (int i = 0; i < NDIG; i++) begin
      digit_d[i] = digit_q[i];
      if (wr_en && (wr_idx == IW'(i))) begin
        digit_d[i] = wr_val;
      end
    end
  end

  // zero_from[i] is set when digit i and every more-significant digit is zero.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    zero_from = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_run     = zero_run & (digit_q[i] == 4'h0);
      zero_from[i] = zero_run;
    end
  end

  always_comb begin
    cur_val = 4'h0;
    cur_blk = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_q == IW'(i)) begin
        cur_val = digit_q[i];
        cur_blk = blank_mask[i] | (lz_en && (i != 0) && zero_from[i]);
      end
    end
  end

  assign idx_wrap = (idx_q == IDX_LAST);
  assign idx_next = idx_wrap ? '0 : idx_q + IW'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    frame_d = 1'b0;

    if (!en) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_SHOW: begin
          if (cnt_q == DIV_LAST) begin
            cnt_d = '0;
            if (GAP == 0) begin
              idx_d   = idx_next;
              frame_d = idx_wrap;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            idx_d   = idx_next;
            frame_d = idx_wrap;
            state_d = ST_SHOW;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    dec_b     = 4'h0;
    dec_clear = 1'b1;
    digit_sel = '1;
    case (state_q)
      ST_SHOW: begin
        dec_b     = cur_val;
        dec_clear = cur_blk;
        digit_sel = ~(NDIG'(1) << idx_q);
      end
      ST_GAP: begin
        dec_b = cur_val;
      end
      default: ;
    endcase
  end

  assign frame_done = frame_q;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      frame_q <= 1'b0;
      // NOTE: the digit file is a handful of flops that must read as zero after reset, so it is reset too.
      for (int i = 0; i < NDIG; i++) begin
        digit_q[i] <= 4'h0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      for (int i = 0; i < NDIG; i++) begin
        digit_q[i] <= digit_d[i];
      end
    end
  end

endmodule
